// File: rtl/fir_sequencer.sv
// FIR sequencer: pulls one I/Q sample per pass, shifts the delay line,
// steps the datapath phase 0..2 and offers the summed result downstream.
module fir_sequencer #(
  parameter int SAMP_W    = 24,
  parameter int NTAPS     = 29,
  parameter int PP_W      = 51,
  parameter bit SKIP_FILL = 1'b1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Enable,
  input  logic                      FifoEmpty,
  input  logic [2*SAMP_W-1:0]       FifoData,
  output logic                      PullOut,
  output logic [NTAPS*2*SAMP_W-1:0] samp_flat,
  output logic [1:0]                count,
  input  logic [5*2*PP_W-1:0]       sub_prod,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [PP_W+2:0]           OutI,
  output logic [PP_W+2:0]           OutQ,
  output logic                      Busy
);

  localparam int SW = 2 * SAMP_W;
  localparam int DW = NTAPS * SW;
  localparam int FW = $clog2(NTAPS + 1);
  localparam int RW = PP_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0,
    S_P1,
    S_P2,
    S_OUT
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   line_q, line_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [RW-1:0]   oi_q, oi_d;
  logic [RW-1:0]   oq_q, oq_d;
  logic            keep_q, keep_d;
  logic [RW-1:0]   sum_i, sum_q;
  logic [PP_W-1:0] pi, pq;

  // Three guard bits make the five-term sum overflow-free
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    pi    = '0;
    pq    = '0;
    for (int k = 0; k < 5; k++) begin
      pi    = sub_prod[k*2*PP_W+PP_W +: PP_W];
      pq    = sub_prod[k*2*PP_W +: PP_W];
      sum_i = sum_i + {{3{pi[PP_W-1]}}, pi};
      sum_q = sum_q + {{3{pq[PP_W-1]}}, pq};
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    fill_d  = fill_q;
    oi_d    = oi_q;
    oq_d    = oq_q;
    keep_d  = keep_q;
    PullOut = 1'b0;
    count   = 2'd0;
    unique case (state_q)
      S_IDLE: begin
        PullOut = Reset & Enable & ~FifoEmpty;
        if (PullOut) begin
          line_d  = {line_q[DW-SW-1:0], FifoData};
          state_d = S_P0;
          if (fill_q != FW'(NTAPS)) begin
            fill_d = fill_q + FW'(1);
          end
        end
      end
      S_P0: state_d = S_P1;
      S_P1: begin
        count   = 2'd1;
        state_d = S_P2;
      end
      S_P2: begin
        count   = 2'd2;
        oi_d    = sum_i;
        oq_d    = sum_q;
        keep_d  = !SKIP_FILL || (fill_q == FW'(NTAPS));
        state_d = S_OUT;
      end
      S_OUT: begin
        // A discarded fill-phase result leaves without a handshake
        if (!keep_q || OutReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      fill_q  <= '0;
      oi_q    <= '0;
      oq_q    <= '0;
      keep_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      fill_q  <= fill_d;
      oi_q    <= oi_d;
      oq_q    <= oq_d;
      keep_q  <= keep_d;
    end
  end

  assign samp_flat = line_q;
  assign OutValid  = (state_q == S_OUT) & keep_q;
  assign OutI      = oi_q;
  assign OutQ      = oq_q;
  assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: timeline model of both fill modes plus
// directed checks of latency, fill, stall, enable drop and reset abort.
module tb_fir_sequencer;

  localparam int NTAPS = 29;
  localparam int PP_W  = 51;
  localparam int SW    = 48;
  localparam int DW    = NTAPS * SW;
  localparam int RW    = PP_W + 3;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Enable = 1'b1;
  logic              OutReady = 1'b1;
  logic [10*PP_W-1:0] sub_prod = '0;
  logic              FifoEmpty;
  logic [SW-1:0]     FifoData;

  logic [SW-1:0] fmem [64];
  int            rd = 0;
  int            wr = 0;

  assign FifoEmpty = (rd == wr);
  assign FifoData  = fmem[rd[5:0]];

  logic          po  [2];
  logic [DW-1:0] sf  [2];
  logic [1:0]    cnt [2];
  logic          ov  [2];
  logic [RW-1:0] oi  [2];
  logic [RW-1:0] oq  [2];
  logic          bsy [2];

  fir_sequencer #(.SKIP_FILL(1'b0)) u_nofill (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .FifoEmpty(FifoEmpty), .FifoData(FifoData),
    .PullOut(po[0]), .samp_flat(sf[0]), .count(cnt[0]),
    .sub_prod(sub_prod), .OutValid(ov[0]),
    .OutReady(OutReady), .OutI(oi[0]), .OutQ(oq[0]),
    .Busy(bsy[0])
  );

  fir_sequencer #(.SKIP_FILL(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .FifoEmpty(FifoEmpty), .FifoData(FifoData),
    .PullOut(po[1]), .samp_flat(sf[1]), .count(cnt[1]),
    .sub_prod(sub_prod), .OutValid(ov[1]),
    .OutReady(OutReady), .OutI(oi[1]), .OutQ(oq[1]),
    .Busy(bsy[1])
  );

  always #5 Clk = ~Clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] samp(input int n);
    if (n == 1) return 48'h400000_000000;
    return {24'(n * 4097), 24'(-n * 3)};
  endfunction

  task automatic set_sp(input logic [PP_W-1:0] i, input logic [PP_W-1:0] q);
    for (int k = 0; k < 5; k++) begin
      sub_prod[k*2*PP_W+PP_W +: PP_W] = i;
      sub_prod[k*2*PP_W +: PP_W]      = q;
    end
  endtask

  // Sum of the five signed sub-products; hi=1 selects I, 0 selects Q
  function automatic logic [RW-1:0] psum(input int hi);
    longint s = 0;
    for (int k = 0; k < 5; k++)
      s += longint'($signed(sub_prod[k*2*PP_W+hi*PP_W +: PP_W]));
    return RW'(s);
  endfunction

  // Model: mt = cycles since the pull (0 idle, 1..3 phases, >=4 output)
  int            mt    [2];
  int            mfill [2];
  logic          mkeep [2];
  logic [RW-1:0] mi    [2];
  logic [RW-1:0] mq    [2];
  logic [SW-1:0] dl    [2][NTAPS];

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int d = 0; d < 2; d++) begin
        mt[d] <= 0; mfill[d] <= 0; mkeep[d] <= 1'b0;
        mi[d] <= '0; mq[d] <= '0;
        for (int k = 0; k < NTAPS; k++) dl[d][k] <= '0;
      end
    end else begin
      if (mt[1] == 0 && Enable && !FifoEmpty) rd <= rd + 1;
      for (int d = 0; d < 2; d++) begin
        if (mt[d] == 0) begin
          if (Enable && !FifoEmpty) begin
            dl[d][0] <= FifoData;
            for (int k = 1; k < NTAPS; k++) dl[d][k] <= dl[d][k-1];
            mfill[d] <= (mfill[d] < NTAPS) ? mfill[d] + 1 : NTAPS;
            mt[d] <= 1;
          end
        end else if (mt[d] < 3) begin
          mt[d] <= mt[d] + 1;
        end else if (mt[d] == 3) begin
          mi[d] <= psum(1);
          mq[d] <= psum(0);
          mkeep[d] <= (d == 0) || (mfill[d] == NTAPS);
          mt[d] <= 4;
        end else if (!mkeep[d] || OutReady) begin
          mt[d] <= 0;
        end else begin
          mt[d] <= mt[d] + 1;
        end
      end
    end
  end

  logic [DW-1:0] es;
  logic [1:0]    ecnt;
  int            bad;

  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) begin
      ecnt = (mt[d] == 2) ? 2'd1 : (mt[d] == 3) ? 2'd2 : 2'd0;
      chk($sformatf("pull%0d", d), 64'(po[d]),
          64'(Reset && mt[d] == 0 && Enable && !FifoEmpty));
      chk($sformatf("count%0d", d), 64'(cnt[d]), 64'(ecnt));
      chk($sformatf("valid%0d", d), 64'(ov[d]), 64'(mt[d] >= 4 && mkeep[d]));
      chk($sformatf("busy%0d", d), 64'(bsy[d]), 64'(mt[d] != 0));
      chk($sformatf("outi%0d", d), 64'(oi[d]), 64'(mi[d]));
      chk($sformatf("outq%0d", d), 64'(oq[d]), 64'(mq[d]));
      for (int k = 0; k < NTAPS; k++) es[k*SW +: SW] = dl[d][k];
      nchk++;
      if (sf[d] !== es) begin
        nerr++;
        bad = 0;
        for (int k = NTAPS - 1; k >= 0; k--)
          if (sf[d][k*SW +: SW] !== es[k*SW +: SW]) bad = k;
        $display("FAIL samp%0d entry %0d: got %h expected %h", d, bad,
                 sf[d][bad*SW +: SW], es[bad*SW +: SW]);
      end
    end
  end

  int            npull1 = 0;
  int            nval1  = 0;
  int            ntx    = 0;
  int            p_first = 0;
  int            p_second = 0;
  logic          ov1_d = 1'b0;
  logic [SW-1:0] s28_cap = '0;
  logic [RW-1:0] oi29 = '0;
  logic [RW-1:0] oq29 = '0;

  always @(negedge Clk) begin
    if (po[1] === 1'b1) npull1 <= npull1 + 1;
    if (ov[1] === 1'b1 && OutReady) ntx <= ntx + 1;
    if (ov[1] === 1'b1 && !ov1_d) begin
      nval1 <= nval1 + 1;
      if (nval1 == 0) begin
        p_first <= npull1;
        s28_cap <= sf[1][28*SW +: SW];
        oi29    <= oi[1];
        oq29    <= oq[1];
      end else if (nval1 == 1) begin
        p_second <= npull1;
      end
    end
    ov1_d <= ov[1];
  end

  int            c0;
  int            t0;
  int            v6;
  logic [RW-1:0] hold;

  initial begin
    for (int n = 1; n <= 30; n++) fmem[n-1] = samp(n);
    wr = 30;
    set_sp(51'd1, 51'd2);

    repeat (3) begin
      @(negedge Clk);
      chk("rst_pull", 64'(po[1]), 64'd0);
      chk("rst_valid", 64'(ov[1]), 64'd0);
      chk("rst_samp", 64'(|sf[1]), 64'd0);
    end

    @(posedge Clk); #2 Reset = 1'b1;
    @(negedge Clk);
    chk("t2_pull", 64'(po[0]), 64'd1);
    c0 = cyc;
    @(negedge Clk);
    chk("t2_p0", 64'({bsy[0], cnt[0]}), 64'b100);
    @(negedge Clk);
    chk("t2_p1", 64'(cnt[0]), 64'd1);
    @(negedge Clk);
    chk("t2_p2", 64'(cnt[0]), 64'd2);
    @(negedge Clk);
    chk("t2_valid", 64'(ov[0]), 64'd1);
    chk("t2_latency", 64'(cyc - c0), 64'd4);
    chk("t2_outi", 64'(oi[0]), 64'd5);
    chk("t2_outq", 64'(oq[0]), 64'd10);
    chk("t2_skip_quiet", 64'(ov[1]), 64'd0);

    @(posedge Clk); #1;
    set_sp('1, 51'h3FFFFFFFFFFFF);
    for (int i = 0; i < 400 && !(rd == wr && !bsy[1]); i++)
      @(negedge Clk);
    chk("t3_drain", 64'(rd == wr && !bsy[1]), 64'd1);
    chk("t3_nvalid", 64'(nval1), 64'd2);
    chk("t3_first_pass", 64'(p_first), 64'd29);
    chk("t3_second_pass", 64'(p_second), 64'd30);
    chk("t3_entry28", 64'(s28_cap), 64'(samp(1)));
    chk("t3_outi_neg", 64'(oi29), 64'h3FFFFFFFFFFFFB);
    chk("t3_outq_max", 64'(oq29), 64'h13FFFFFFFFFFFB);

    @(posedge Clk); #1;
    OutReady = 1'b0;
    fmem[30] = samp(31);
    fmem[31] = samp(32);
    wr = 32;
    for (int i = 0; i < 20 && ov[1] !== 1'b1; i++) @(negedge Clk);
    chk("t4_reach_out", 64'(ov[1]), 64'd1);
    hold = oi[1];
    repeat (10) begin
      @(negedge Clk);
      chk("t4_stable", 64'(oi[1]), 64'(hold));
      chk("t4_no_pull", 64'(po[1]), 64'd0);
      chk("t4_hold_valid", 64'(ov[1]), 64'd1);
    end
    @(posedge Clk); #1;
    OutReady = 1'b1;
    t0 = ntx;
    @(negedge Clk);
    @(negedge Clk);
    chk("t4_valid_drop", 64'(ov[1]), 64'd0);
    chk("t4_one_xfer", 64'(ntx - t0), 64'd1);

    for (int i = 0; i < 20 && cnt[1] !== 2'd1; i++) @(negedge Clk);
    chk("t5_reach_p1", 64'(cnt[1]), 64'd1);
    #1;
    Enable = 1'b0;
    fmem[32] = samp(33);
    wr = 33;
    for (int i = 0; i < 20 && ov[1] !== 1'b1; i++) @(negedge Clk);
    chk("t5_delivered", 64'(ov[1]), 64'd1);
    repeat (3) begin
      @(negedge Clk);
      chk("t5_no_pull", 64'(po[1]), 64'd0);
      chk("t5_idle", 64'(bsy[1]), 64'd0);
      chk("t5_fifo_full", 64'(FifoEmpty), 64'd0);
    end

    @(posedge Clk); #1;
    Enable = 1'b1;
    v6 = nval1;
    for (int i = 0; i < 20 && cnt[1] !== 2'd2; i++) @(negedge Clk);
    chk("t6_reach_p2", 64'(cnt[1]), 64'd2);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("t6_valid", 64'(ov[1]), 64'd0);
    chk("t6_outi", 64'(oi[1]), 64'd0);
    chk("t6_samp", 64'(|sf[1]), 64'd0);
    chk("t6_busy", 64'(bsy[1]), 64'd0);
    @(posedge Clk); #2;
    Reset = 1'b1;
    fmem[33] = samp(34);
    wr = 34;
    for (int i = 0; i < 20 && bsy[1] !== 1'b1; i++) @(negedge Clk);
    for (int i = 0; i < 20 && bsy[1] !== 1'b0; i++) @(negedge Clk);
    chk("t6_pass_done", 64'(bsy[1]), 64'd0);
    chk("t6_no_valid", 64'(nval1 - v6), 64'd0);
    chk("t6_entry0", 64'(sf[1][SW-1:0]), 64'(samp(34)));
    chk("t6_entry1", 64'(sf[1][2*SW-1:SW]), 64'd0);

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
